// File: rtl/instr_prefetch_unit_pkg.sv
// instr_prefetch_unit_pkg: shared FSM state type and constants for the prefetch unit
package instr_prefetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/instr_prefetch_unit_if.sv
// instr_prefetch_unit_if: redirect, instruction-memory and core-delivery signals of the prefetch unit
interface instr_prefetch_unit_if
    import instr_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic                     mem_ack;
    logic [31:0]              mem_rdata;
    logic                     out_valid;
    logic [31:0]              out_instr;
    logic [31:0]              out_pc;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   occupancy;
    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc, occupancy
    );
    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, occupancy
    );
endinterface

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of {pc, instr} entries with flush and occupancy count
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: sequential instruction prefetcher with redirect flush and a small queue
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEF,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_prefetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count, occ_after;
    logic [63:0]   head;
    logic          push, pop, room;
    // redirect flushes the queue, so it masks both queue operations
    assign pop       = bus.out_valid & bus.out_ready & ~bus.redirect;
    assign push      = (state == REQ) & bus.mem_ack & ~bus.redirect;
    assign occ_after = count + CW'(push) - CW'(pop);
    assign room      = occ_after < CW'(DEPTH);
    assign bus.occupancy = count;
    assign bus.out_valid = count != '0;
    assign bus.out_pc    = bus.out_valid ? head[63:32] : '0;
    assign bus.out_instr = bus.out_valid ? head[31:0] : '0;
    prefetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc, bus.mem_rdata}),
        .dout  (head),
        .count (count)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            if (bus.redirect) fetch_pc <= bus.redirect_pc;
            else if (push) fetch_pc <= fetch_pc + PC_STEP;
            case (state)
                IDLE: if (bus.redirect || room) begin
                    state        <= REQ;
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= bus.redirect ? bus.redirect_pc : fetch_pc;
                end
                REQ: if (bus.redirect) begin
                    if (bus.mem_ack) bus.mem_addr <= bus.redirect_pc;
                    else state <= DRAIN;
                end else if (bus.mem_ack) begin
                    if (room) bus.mem_addr <= fetch_pc + PC_STEP;
                    else begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end
                end
                // stale request: swallow its ack, then restart at the newest target
                DRAIN: if (bus.mem_ack) begin
                    state        <= REQ;
                    bus.mem_addr <= bus.redirect ? bus.redirect_pc : fetch_pc;
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
